// File: rtl/al_dec_scan_sequencer.sv
// Registered active-low N-to-2^N decoder with a built-in scan sequencer.
// Direct mode latches an address; scan mode walks one low line across all outputs.
module al_dec_scan_sequencer #(
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        a,
    output logic [(1<<N)-1:0]   Y,
    output logic [N-1:0]        sel,
    output logic                wrap
);

    localparam int              DW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DCNT_LAST = DW'(DWELL - 1);
    localparam logic [N-1:0]    SEL_LAST  = '1;

    logic [N-1:0]  r_sel,  w_sel_next;
    logic          r_act,  w_act_next;
    logic [DW-1:0] r_dcnt, w_dcnt_next;
    logic          r_wrap, w_wrap_next;

    always_comb begin
        w_sel_next  = r_sel;
        w_act_next  = r_act;
        w_dcnt_next = r_dcnt;
        w_wrap_next = 1'b0;
        if (en) begin
            // Disabled: blank the outputs but keep sel/dcnt so the scan resumes in place.
            w_act_next = 1'b0;
        end else if (!mode) begin
            w_sel_next  = a;
            w_act_next  = 1'b1;
            w_dcnt_next = '0;
        end else if (!r_act) begin
            // Line was not driven last cycle, so this edge does not count as dwell.
            w_act_next = 1'b1;
        end else if (r_dcnt < DCNT_LAST) begin
            w_dcnt_next = r_dcnt + 1'b1;
        end else begin
            w_dcnt_next = '0;
            w_sel_next  = r_sel + 1'b1;
            w_wrap_next = (r_sel == SEL_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel  <= '0;
            r_act  <= 1'b0;
            r_dcnt <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_sel  <= w_sel_next;
            r_act  <= w_act_next;
            r_dcnt <= w_dcnt_next;
            r_wrap <= w_wrap_next;
        end
    end

    generate
        for (genvar gi = 0; gi < (1 << N); gi++) begin : g_line
            assign Y[gi] = ~(r_act && (r_sel == N'(gi)));
        end
    endgenerate

    assign sel  = r_sel;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_al_dec_scan_sequencer.sv
// Directed bench for al_dec_scan_sequencer: N=4/DWELL=4 instance plus an N=3/DWELL=1 instance.
module tb_al_dec_scan_sequencer;

    logic        clk;
    logic        rst;
    logic        en, mode;
    logic [3:0]  a;
    logic [15:0] y;
    logic [3:0]  sel;
    logic        wrap;

    logic        en3, mode3;
    logic [2:0]  a3;
    logic [7:0]  y3;
    logic [2:0]  sel3;
    logic        wrap3;

    int checks   = 0;
    int failures = 0;

    al_dec_scan_sequencer #(.N(4), .DWELL(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a),
        .Y(y), .sel(sel), .wrap(wrap)
    );

    al_dec_scan_sequencer #(.N(3), .DWELL(1)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .mode(mode3), .a(a3),
        .Y(y3), .sel(sel3), .wrap(wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] line16(input int s);
        logic [15:0] one;
        one = 16'h0001;
        return ~(one << s);
    endfunction

    function automatic logic [7:0] line8(input int s);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << s);
    endfunction

    initial begin
        int es;
        rst = 1'b1; en = 1'b1; mode = 1'b0; a = '0;
        en3 = 1'b1; mode3 = 1'b1; a3 = '0;
        #3;
        chk("rst_y",    32'(y),    32'hFFFF);
        chk("rst_sel",  32'(sel),  32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);

        // Direct sweep
        en = 1'b0; mode = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            step();
            chk($sformatf("dir_y_a%0d", i),   32'(y),    32'(line16(i)));
            chk($sformatf("dir_sel_a%0d", i), 32'(sel),  32'(i));
            chk($sformatf("dir_wrap_a%0d", i),32'(wrap), 32'h0);
        end

        // Scan period from reset
        mode = 1'b1;
        do_reset();
        for (int e = 1; e <= 66; e++) begin
            step();
            es = ((e - 1) / 4) % 16;
            chk($sformatf("scan_y_e%0d", e),    32'(y),    32'(line16(es)));
            chk($sformatf("scan_sel_e%0d", e),  32'(sel),  32'(es));
            chk($sformatf("scan_wrap_e%0d", e), 32'(wrap), (e == 65) ? 32'h1 : 32'h0);
        end

        // Asynchronous reset mid-scan at sel=9, dcnt=2 (edge 39)
        do_reset();
        for (int e = 1; e <= 39; e++) step();
        chk("pre_rst_sel", 32'(sel), 32'h9);
        rst = 1'b1;
        #1;
        chk("async_rst_y",    32'(y),    32'hFFFF);
        chk("async_rst_sel",  32'(sel),  32'h0);
        chk("async_rst_wrap", 32'(wrap), 32'h0);
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_y",   32'(y),   32'hFFFE);
        chk("post_rst_sel", 32'(sel), 32'h0);

        // Pause/resume at sel=7, dcnt=2 (edge 31)
        do_reset();
        for (int e = 1; e <= 31; e++) step();
        chk("pause_pre_y", 32'(y), 32'hFF7F);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("pause_y_%0d", i),   32'(y),   32'hFFFF);
            chk($sformatf("pause_sel_%0d", i), 32'(sel), 32'h7);
        end
        en = 1'b0;
        step();
        chk("resume_y_1", 32'(y), 32'hFF7F);
        step();
        chk("resume_y_2", 32'(y), 32'hFF7F);
        step();
        chk("resume_sel", 32'(sel), 32'h8);
        chk("resume_y_3", 32'(y),   32'hFEFF);

        // Mode switch scan(sel=3) -> direct(a=10) -> scan
        do_reset();
        for (int e = 1; e <= 13; e++) step();
        chk("msw_pre_sel", 32'(sel), 32'h3);
        mode = 1'b0; a = 4'd10;
        step();
        chk("msw_dir_y",    32'(y),    32'hFBFF);
        chk("msw_dir_sel",  32'(sel),  32'hA);
        chk("msw_dir_wrap", 32'(wrap), 32'h0);
        mode = 1'b1; a = 4'd2;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("msw_hold_y_%0d", i), 32'(y), 32'hFBFF);
        end
        step();
        chk("msw_adv_sel", 32'(sel), 32'hB);
        chk("msw_adv_y",   32'(y),   32'hF7FF);

        // DWELL=1, N=3 instance
        en = 1'b1;
        en3 = 1'b0; mode3 = 1'b1;
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            step();
            es = (e - 1) % 8;
            chk($sformatf("d1_y_e%0d", e),    32'(y3),    32'(line8(es)));
            chk($sformatf("d1_wrap_e%0d", e), 32'(wrap3), (e > 1 && es == 0) ? 32'h1 : 32'h0);
        end

        // Disable blanks the outputs one edge later
        en3 = 1'b1;
        step();
        chk("d1_dis_y",    32'(y3),    32'hFF);
        chk("d1_dis_wrap", 32'(wrap3), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
